// File: rtl/muxn_pipe_stage_if.sv
`default_nettype none
// ============================================================================
// Module : muxn_pipe_stage_if
// Desc   : Handshake bundle for muxn_pipe_stage (upstream, flush, downstream)
// Rev    : 1.0
// ============================================================================
interface muxn_pipe_stage_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, out_err, out_valid
  );

  modport slave (
    input  in_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, out_err, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/muxn_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module : muxn_pipe_stage
// Desc   : N:1 select with registered output, two-entry skid buffer, flush
// Rev    : 1.0
// ============================================================================
module muxn_pipe_stage #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  wire                 clk,
  input  wire                 rst,
  muxn_pipe_stage_if.slave    bus
);

  if (NUM_IN < 2 || NUM_IN > 16 || (2**SEL_W) < NUM_IN) begin : g_param_err
    $error("muxn_pipe_stage: illegal NUM_IN/SEL_W combination");
  end

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;

  logic [WIDTH-1:0] mux_data;
  logic             mux_err;

  logic [WIDTH-1:0] main_data;
  logic [SEL_W-1:0] main_sel;
  logic             main_err;
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic             skid_err;

  logic             accept;
  logic             take;
  logic             load_main_in;
  logic             load_skid_in;
  logic             move_skid;

  // Out-of-range selects never match a lane, so they leave data at zero and err set.
  always_comb begin
    mux_data = '0;
    mux_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        mux_data = bus.in_data[k*WIDTH +: WIDTH];
        mux_err  = 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state != ST_FULL) & ~bus.flush & ~rst;
  assign bus.out_valid = (state != ST_EMPTY);
  assign bus.out_data  = main_data;
  assign bus.out_sel   = main_sel;
  assign bus.out_err   = main_err;

  assign accept = bus.in_valid & bus.in_ready;
  assign take   = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_nxt = ST_ONE;
        ST_ONE: begin
          if (accept && !take)      state_nxt = ST_FULL;
          else if (!accept && take) state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (take) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // accept is already zero during flush; only the skid move needs explicit gating.
  always_comb begin
    load_main_in = 1'b0;
    load_skid_in = 1'b0;
    move_skid    = 1'b0;
    case (state)
      ST_EMPTY: load_main_in = accept;
      ST_ONE: begin
        load_main_in = accept & take;
        load_skid_in = accept & ~take;
      end
      ST_FULL:  move_skid = take & ~bus.flush;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_data <= '0;
      main_sel  <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_sel  <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_data <= mux_data;
        main_sel  <= bus.sel;
        main_err  <= mux_err;
      end else if (move_skid) begin
        main_data <= skid_data;
        main_sel  <= skid_sel;
        main_err  <= skid_err;
      end
      if (load_skid_in) begin
        skid_data <= mux_data;
        skid_sel  <= bus.sel;
        skid_err  <= mux_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muxn_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_muxn_pipe_stage
// Desc   : Directed-vector bench for muxn_pipe_stage (NUM_IN=4 and NUM_IN=3)
// ============================================================================
module tb_muxn_pipe_stage;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] D0 = 32'hAAAA0000;
  localparam logic [31:0] D1 = 32'hBBBB0001;
  localparam logic [31:0] D2 = 32'hCCCC0002;
  localparam logic [31:0] D3 = 32'hDDDD0003;

  logic [31:0] dv [4];

  always #5 clk = ~clk;

  muxn_pipe_stage_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) bus4 ();
  muxn_pipe_stage_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) bus3 ();

  muxn_pipe_stage #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  muxn_pipe_stage #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    dv[0] = D0; dv[1] = D1; dv[2] = D2; dv[3] = D3;

    rst            = 1'b1;
    bus4.in_data   = {D3, D2, D1, D0};
    bus4.sel       = '0;
    bus4.in_valid  = 1'b0;
    bus4.flush     = 1'b0;
    bus4.out_ready = 1'b0;
    bus3.in_data   = {D2, D1, D0};
    bus3.sel       = '0;
    bus3.in_valid  = 1'b0;
    bus3.flush     = 1'b0;
    bus3.out_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_out_valid", 64'(bus4.out_valid), 64'd0);
    check("rst_out_data",  64'(bus4.out_data),  64'd0);
    check("rst_out_sel",   64'(bus4.out_sel),   64'd0);
    check("rst_out_err",   64'(bus4.out_err),   64'd0);
    check("rst_in_ready",  64'(bus4.in_ready),  64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(bus4.in_ready), 64'd1);

    // Single transfer, 1-cycle latency
    bus4.sel = 2'd2; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    step();
    check("t1_out_valid", 64'(bus4.out_valid), 64'd1);
    check("t1_out_data",  64'(bus4.out_data),  64'(D2));
    check("t1_out_sel",   64'(bus4.out_sel),   64'd2);
    check("t1_out_err",   64'(bus4.out_err),   64'd0);
    bus4.in_valid = 1'b0;
    step();
    check("t1_drain_valid", 64'(bus4.out_valid), 64'd0);

    // Streaming with no bubbles
    for (int i = 0; i < 4; i++) begin
      bus4.sel = 2'(i); bus4.in_valid = 1'b1;
      #1;
      check("stream_in_ready", 64'(bus4.in_ready), 64'd1);
      step();
      check("stream_out_valid", 64'(bus4.out_valid), 64'd1);
      check("stream_out_data",  64'(bus4.out_data),  64'(dv[i]));
    end
    bus4.in_valid = 1'b0;
    step();
    check("stream_drain_valid", 64'(bus4.out_valid), 64'd0);

    // Backpressure fills skid, then drains in order
    bus4.out_ready = 1'b0;
    bus4.sel = 2'd1; bus4.in_valid = 1'b1;
    step();
    check("bp_in_ready_one", 64'(bus4.in_ready), 64'd1);
    bus4.sel = 2'd3;
    step();
    bus4.in_valid = 1'b0;
    #1;
    check("bp_in_ready_full", 64'(bus4.in_ready), 64'd0);
    check("bp_hold_data0",    64'(bus4.out_data), 64'(D1));
    step();
    check("bp_hold_valid",    64'(bus4.out_valid), 64'd1);
    check("bp_hold_data1",    64'(bus4.out_data),  64'(D1));
    check("bp_hold_sel",      64'(bus4.out_sel),   64'd1);
    bus4.out_ready = 1'b1;
    #1;
    check("bp_head_first",    64'(bus4.out_data), 64'(D1));
    step();
    check("bp_head_second",   64'(bus4.out_data), 64'(D3));
    check("bp_second_valid",  64'(bus4.out_valid), 64'd1);
    check("bp_in_ready_back", 64'(bus4.in_ready), 64'd1);
    step();
    check("bp_drain_valid",   64'(bus4.out_valid), 64'd0);

    // Flush while FULL with an input offered
    bus4.out_ready = 1'b0;
    bus4.sel = 2'd0; bus4.in_valid = 1'b1;
    step();
    bus4.sel = 2'd1;
    step();
    bus4.sel = 2'd2; bus4.flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(bus4.in_ready), 64'd0);
    step();
    bus4.flush = 1'b0; bus4.in_valid = 1'b0;
    #1;
    check("flush_out_valid", 64'(bus4.out_valid), 64'd0);
    check("flush_in_ready_after", 64'(bus4.in_ready), 64'd1);
    bus4.out_ready = 1'b1;
    step();
    check("flush_no_ghost0", 64'(bus4.out_valid), 64'd0);
    step();
    check("flush_no_ghost1", 64'(bus4.out_valid), 64'd0);

    // Reset while FULL
    bus4.out_ready = 1'b0;
    bus4.sel = 2'd3; bus4.in_valid = 1'b1;
    step();
    bus4.sel = 2'd2;
    step();
    check("prerst_full_in_ready", 64'(bus4.in_ready), 64'd0);
    rst = 1'b1; bus4.in_valid = 1'b0;
    #1;
    check("midrst_in_ready", 64'(bus4.in_ready), 64'd0);
    step();
    check("midrst_out_valid", 64'(bus4.out_valid), 64'd0);
    check("midrst_out_data",  64'(bus4.out_data),  64'd0);
    check("midrst_out_sel",   64'(bus4.out_sel),   64'd0);
    check("midrst_out_err",   64'(bus4.out_err),   64'd0);
    rst = 1'b0;
    bus4.sel = 2'd1; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    step();
    check("postrst_valid", 64'(bus4.out_valid), 64'd1);
    check("postrst_data",  64'(bus4.out_data),  64'(D1));
    bus4.in_valid = 1'b0;
    step();
    check("postrst_drain", 64'(bus4.out_valid), 64'd0);

    // Out-of-range select on the 3-input instance
    bus3.sel = 2'd3; bus3.in_valid = 1'b1; bus3.out_ready = 1'b1;
    step();
    check("oor_valid", 64'(bus3.out_valid), 64'd1);
    check("oor_data",  64'(bus3.out_data),  64'd0);
    check("oor_err",   64'(bus3.out_err),   64'd1);
    check("oor_sel",   64'(bus3.out_sel),   64'd3);
    bus3.sel = 2'd0;
    step();
    check("inr_err",  64'(bus3.out_err),  64'd0);
    check("inr_data", 64'(bus3.out_data), 64'(D0));
    check("inr_sel",  64'(bus3.out_sel),  64'd0);
    bus3.sel = 2'd2;
    step();
    check("inr2_data", 64'(bus3.out_data), 64'(D2));
    bus3.in_valid = 1'b0;
    step();
    check("oor_drain", 64'(bus3.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muxn_pipe_stage.md
Name: muxn_pipe_stage

Overview:
- Parametrised N:1 data selector with a registered output and a valid/ready handshake.
- Uses a two-entry skid buffer so the pipeline keeps full throughput under downstream backpressure.
- Replaces ad-hoc combinational 4:1 selects on datapath boundaries where the selected operand must be registered and stall-tolerant, e.g. the ALU operand-select to EX stage.
- Adds flush support for branch/exception squash and out-of-range select detection.

Parameters:
- WIDTH, 32: data width of each input and of the output.
- NUM_IN, 4: number of data inputs; legal range 2..16.
- SEL_W, 2: select width; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH], input 0 at the LSBs.
- sel  input  SEL_W  selects input index; sampled with in_valid.
- in_valid  input  1  upstream has a transfer.
- in_ready  output  1  stage can accept a transfer.
- flush  input  1  squash all held entries.
- out_data  output  WIDTH  selected data of the head entry.
- out_sel  output  SEL_W  sel value captured with the head entry.
- out_err  output  1  head entry had an out-of-range sel.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head entry.

Behaviour:
- Definitions:
  - Accept = in_valid & in_ready.
  - Take = out_valid & out_ready.
- Entry contents: {data, sel, err}.
  - If sel < NUM_IN: data = input[sel], err = 0.
  - If sel >= NUM_IN: data = 0, err = 1.
  - The mux is evaluated combinationally at the input; only the result is stored.
- Storage: main register (drives the out_* ports) and skid register.
- States:
  - EMPTY: main and skid invalid.
  - ONE: main valid.
  - FULL: main and skid valid.
- Transitions:
  - EMPTY: Accept -> ONE, entry loaded to main.
  - ONE:
    - Accept and Take -> ONE, main reloaded with the new entry.
    - Accept only -> FULL, new entry goes to skid.
    - Take only -> EMPTY.
    - Neither -> ONE.
  - FULL: Take -> ONE, skid moves to main. No Accept is possible in FULL.
- in_ready = ~skid_valid & ~flush & ~rst. It is a function of registered state plus flush and rst; it does not depend combinationally on out_ready.
- Latency: 1 cycle from Accept to out_valid when EMPTY. Throughput is 1 per cycle while out_ready stays high.
- Ordering: strictly FIFO; no entry is dropped or duplicated except by flush or rst.
- Stability: while out_valid=1 and out_ready=0, out_data/out_sel/out_err hold their values.
- Flush:
  - Next state is EMPTY; main and skid valid bits are cleared.
  - Any input presented in the flush cycle is discarded (in_ready=0).
  - A Take in the flush cycle still completes downstream.
- Reset:
  - out_valid=0, out_data=0, out_sel=0, out_err=0, skid cleared, state EMPTY.
  - in_ready=0 while rst is high and 1 on the first cycle after rst falls.
  - Reset mid-transfer discards all entries.
- Priority: rst > flush > Take/Accept.
- Data registers load only on a valid update. Data content is not cleared by flush; only the valid bits are.

Test Plan:
- Reset, then NUM_IN=4, WIDTH=32, in_data={D3=0xDDDD0003, D2=0xCCCC0002, D1=0xBBBB0001, D0=0xAAAA0000}, sel=2, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=0xCCCC0002, out_sel=2, out_err=0.
- Streaming: sel sequence 0,1,2,3 on consecutive cycles with out_ready=1 -> out_data sequence A..,B..,C..,D.. on cycles 1-4, with no bubbles and in_ready held at 1.
- Backpressure: out_ready=0 and two accepts with sel=1 then sel=3 -> in_ready falls to 0 after the second accept (FULL) and out_data holds 0xBBBB0001. Then out_ready=1 -> 0xBBBB0001, then 0xDDDD0003, and in_ready returns to 1.
- Out-of-range: NUM_IN=3, SEL_W=2, sel=3 -> out_data=0, out_err=1, out_sel=3. A following sel=0 entry has out_err=0.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the input presented during flush never appears at the output.
- Reset asserted while FULL -> all outputs 0 the next cycle and in_ready=0 during reset. The first accept after reset appears with 1-cycle latency.
